// File: rtl/spi_alu_pkg.sv
// spi_alu_pkg: shared types, frame sizes and the behavioural ALU model for the SPI ALU master.
package spi_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_INV = 2'd2,
    OP_RED = 2'd3
  } opcode_u;

  localparam int unsigned TX_BITS = 8;
  localparam int unsigned RX_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    GAP
  } state_e;

  function automatic logic [RX_BITS-1:0] alu_model(opcode_u f_op, logic [2:0] f_a, logic [2:0] f_b);
    logic [RX_BITS-1:0] r;
    unique case (f_op)
      OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
      OP_SUB:  r = {1'b0, f_a} - {1'b0, f_b};
      OP_INV:  r = {1'b0, ~f_a};
      OP_RED:  r = {3'b000, |f_b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk by 2*CLK_DIV into sclk while enabled; sclk idles low.
// rise_o/fall_o are registered and flag that the coming clk edge toggles sclk.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          rise_q, fall_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        sclk_d = sclk_q;
      end
    end
  end

  // Strobes are the decode of the next counter state, so they line up with the toggle edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      rise_q <= (CNT_MAX == '0);
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      rise_q <= (cnt_d == CNT_MAX) && !sclk_d;
      fall_q <= (cnt_d == CNT_MAX) && sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_alu_master.sv
// spi_alu_master: sends {op,a,b} LSB first to the SPI ALU slave, then reads back the 4-bit result.
// Define ALU_CHECK_EN to compare each result against a local ALU model (mismatch output).
module spi_alu_master
  import spi_alu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       mismatch,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned   CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] GAP_MAX    = CW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_PULSE = 4'(TX_BITS + RX_BITS - 1);
  localparam logic [3:0]    FIRST_RX   = 4'(TX_BITS);
  localparam logic [3:0]    LAST_TX    = 4'(TX_BITS - 1);

  state_e             state_q, state_d;
  logic [TX_BITS-1:0] tx_q, tx_d;
  logic [RX_BITS-1:0] shift_q, shift_d;
  logic [RX_BITS-1:0] result_q, result_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [CW-1:0]      gap_q, gap_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_en, sclk_rise, sclk_fall;
  logic               accept, frame_end;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (sclk_en),
    .sclk_o(sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  assign accept    = (state_q == IDLE) && start;
  // A rise strobe after pulse 11 marks the end of its low phase; sclk is held low instead.
  assign frame_end = (state_q == XFER) && sclk_rise && (pulse_q == LAST_PULSE);

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    result_d = result_q;
    pulse_d  = pulse_q;
    gap_d    = gap_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_d    = {op, a, b};
          mosi_d  = b[0];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        sclk_en = 1'b1;
        if (sclk_rise) begin
          pulse_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        sclk_en = !frame_end;
        if (frame_end) begin
          cs_d     = 1'b1;
          result_d = shift_q;
          done_d   = 1'b1;
          gap_d    = '0;
          state_d  = GAP;
        end else if (sclk_rise) begin
          pulse_d = pulse_q + 4'd1;
          if (pulse_q < LAST_TX) mosi_d = tx_q[3'(pulse_q + 4'd1)];
        end
        if (sclk_fall && pulse_q >= FIRST_RX) shift_d[pulse_q[1:0]] = miso;
      end
      GAP: begin
        if (gap_q == GAP_MAX) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      shift_q  <= '0;
      result_q <= '0;
      pulse_q  <= '0;
      gap_q    <= '0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      pulse_q  <= pulse_d;
      gap_q    <= gap_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (accept) begin
      mismatch_q <= 1'b0;
    end else if (frame_end) begin
      mismatch_q <= (shift_q != alu_model(opcode_u'(tx_q[7:6]), tx_q[5:3], tx_q[2:0]));
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cs     = cs_q;
  assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_alu_master.sv
// tb_spi_alu_master: drives two masters (CLK_DIV=2 and CLK_DIV=1) against behavioural ALU slaves.
module tb_spi_alu_master;

  logic       clk = 1'b0;
  logic       rst      [2];
  logic       start    [2];
  logic [1:0] op       [2];
  logic [2:0] a        [2];
  logic [2:0] b        [2];
  logic       busy     [2];
  logic       done     [2];
  logic [3:0] result   [2];
  logic       mismatch [2];
  logic       sclk     [2];
  logic       cs       [2];
  logic       mosi     [2];
  logic       miso     [2];
  logic       corrupt  [2];
  logic [7:0] rx_seen  [2];
  int unsigned falls_seen [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [1:0] f_op, input logic [2:0] f_a, input logic [2:0] f_b);
    int r;
    case (f_op)
      2'd0:    r = int'(f_a) + int'(f_b);
      2'd1:    r = int'(f_a) - int'(f_b) + 16;
      2'd2:    r = 7 - int'(f_a);
      default: r = (f_b != 3'd0) ? 1 : 0;
    endcase
    return 4'(r % 16);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        s_miso = 1'b0;
    logic [7:0]  s_rx = '0;
    logic [3:0]  s_res;
    int unsigned s_falls = 0;
    logic        s_cs_p = 1'b1;
    logic        s_sclk_p = 1'b0;

    spi_alu_master #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .start   (start[g]),
      .op      (op[g]),
      .a       (a[g]),
      .b       (b[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .result  (result[g]),
      .mismatch(mismatch[g]),
      .sclk    (sclk[g]),
      .cs      (cs[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g])
    );

    // Slave: samples mosi on sclk falls, drives the result LSB first on rises 8..11.
    always @(cs[g] or sclk[g]) begin
      if (cs[g] !== s_cs_p) begin
        s_miso = 1'b0;
        if (cs[g] === 1'b0) begin
          s_rx    = '0;
          s_falls = 0;
        end
      end else if (cs[g] === 1'b0 && sclk[g] === 1'b1 && s_sclk_p === 1'b0) begin
        if (s_falls >= 8 && s_falls < 12) begin
          s_res  = ref_alu(s_rx[7:6], s_rx[5:3], s_rx[2:0]) ^ (corrupt[g] ? 4'b0100 : 4'b0000);
          s_miso = s_res[s_falls - 8];
        end
      end else if (cs[g] === 1'b0 && sclk[g] === 1'b0 && s_sclk_p === 1'b1) begin
        if (s_falls < 8) s_rx[s_falls] = mosi[g];
        s_falls++;
      end
      s_cs_p   = cs[g];
      s_sclk_p = sclk[g];
    end

    assign miso[g]       = s_miso;
    assign rx_seen[g]    = s_rx;
    assign falls_seen[g] = s_falls;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on instance g; poke_k injects a busy-time start, rst_k aborts with reset.
  task automatic run_frame(input int g, input logic [1:0] f_op, input logic [2:0] f_a, input logic [2:0] f_b,
                           input logic f_corrupt, input int unsigned poke_k, input int unsigned rst_k);
    int unsigned cdiv;
    int unsigned k;
    int unsigned done_k;
    int unsigned busy_k;
    int unsigned n_done;
    logic        mm_at_done;
    logic [3:0]  res_at_done;
    logic [3:0]  exp_res;
    logic        exp_mm;
    cdiv = (g == 0) ? 2 : 1;
    exp_res = ref_alu(f_op, f_a, f_b) ^ (f_corrupt ? 4'b0100 : 4'b0000);
`ifdef ALU_CHECK_EN
    exp_mm = f_corrupt;
`else
    exp_mm = 1'b0;
`endif
    corrupt[g] = f_corrupt;
    @(negedge clk);
    op[g] = f_op; a[g] = f_a; b[g] = f_b; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    op[g] = 2'($urandom); a[g] = 3'($urandom); b[g] = 3'($urandom);
    check("cs_low_after_start", 32'(cs[g]), 32'd0);
    check("busy_after_start", 32'(busy[g]), 32'd1);
    k = 0; done_k = 0; busy_k = 0; n_done = 0; mm_at_done = 1'b0; res_at_done = '0;
    while (k < 40 * cdiv && busy_k == 0) begin
      @(negedge clk);
      k++;
      start[g] = (k == poke_k);
      if (k == poke_k) begin
        op[g] = 2'($urandom); a[g] = 3'($urandom); b[g] = 3'($urandom);
      end
      if (rst_k != 0 && k == rst_k) rst[g] = 1'b1;
      if (rst_k != 0 && k == rst_k + 1) begin
        check("rst_mid_cs", 32'(cs[g]), 32'd1);
        check("rst_mid_sclk", 32'(sclk[g]), 32'd0);
        check("rst_mid_done", 32'(done[g]), 32'd0);
        check("rst_mid_result", 32'(result[g]), 32'd0);
        rst[g] = 1'b0;
      end
      if (done[g] === 1'b1) begin
        n_done++;
        done_k = k;
        mm_at_done = mismatch[g];
        res_at_done = result[g];
      end
      if (busy[g] === 1'b0) busy_k = k;
    end
    start[g] = 1'b0;
    if (rst_k != 0) begin
      check("rst_mid_busy_k", 32'(busy_k), 32'(rst_k + 1));
      for (int i = 0; i < 30 * int'(cdiv); i++) begin
        @(negedge clk);
        if (done[g] === 1'b1) n_done++;
      end
      check("rst_mid_no_done", 32'(n_done), 32'd0);
      check("rst_mid_result_hold", 32'(result[g]), 32'd0);
    end else begin
      check("done_latency", 32'(done_k), 32'(25 * cdiv));
      check("done_count", 32'(n_done), 32'd1);
      check("busy_drop", 32'(busy_k), 32'(26 * cdiv));
      check("result_at_done", 32'(res_at_done), 32'(exp_res));
      check("result_held", 32'(result[g]), 32'(exp_res));
      check("mosi_frame", 32'(rx_seen[g]), 32'({f_op, f_a, f_b}));
      check("sclk_pulses", 32'(falls_seen[g]), 32'd12);
      check("mismatch_at_done", 32'(mm_at_done), 32'(exp_mm));
      check("cs_idle", 32'(cs[g]), 32'd1);
    end
    corrupt[g] = 1'b0;
  endtask

  initial begin
    int unsigned t_prev_fall;
    int unsigned n_fall;
    int unsigned high_run;
    logic        prev_cs;
    logic [1:0]  b_op;
    logic [2:0]  b_a;
    logic [2:0]  b_b;
    int unsigned waited;

    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; op[g] = '0; a[g] = '0; b[g] = '0; corrupt[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_cs", 32'(cs[g]), 32'd1);
      check("reset_sclk", 32'(sclk[g]), 32'd0);
      check("reset_mosi", 32'(mosi[g]), 32'd0);
      check("reset_busy", 32'(busy[g]), 32'd0);
      check("reset_done", 32'(done[g]), 32'd0);
      check("reset_result", 32'(result[g]), 32'd0);
      check("reset_mismatch", 32'(mismatch[g]), 32'd0);
      rst[g] = 1'b0;
    end

    // Directed ALU frames at CLK_DIV=2.
    run_frame(0, 2'd0, 3'd3, 3'd5, 1'b0, 0, 0);
    check("add_3_5", 32'(result[0]), 32'd8);
    run_frame(0, 2'd1, 3'd2, 3'd5, 1'b0, 0, 0);
    check("sub_2_5", 32'(result[0]), 32'd13);
    run_frame(0, 2'd2, 3'd5, 3'd0, 1'b0, 0, 0);
    check("inv_5", 32'(result[0]), 32'd2);
    run_frame(0, 2'd3, 3'd6, 3'd0, 1'b0, 0, 0);
    check("red_b0", 32'(result[0]), 32'd0);
    run_frame(0, 2'd3, 3'd1, 3'd4, 1'b0, 0, 0);
    check("red_b4", 32'(result[0]), 32'd1);

    // Start while busy is ignored; reset mid-frame aborts; next frame completes.
    run_frame(0, 2'd0, 3'd7, 3'd6, 1'b0, 10, 0);
    run_frame(0, 2'd1, 3'd4, 3'd1, 1'b0, 0, 20);
    run_frame(0, 2'd0, 3'd1, 3'd1, 1'b0, 0, 0);

    // Corrupted slave response, then a clean frame.
    run_frame(0, 2'd0, 3'd3, 3'd5, 1'b1, 0, 0);
    run_frame(0, 2'd0, 3'd3, 3'd5, 1'b0, 0, 0);

    // Randomized frames on both instances.
    for (int i = 0; i < 10; i++) begin
      int gi;
      gi = (i < 6) ? 0 : 1;
      run_frame(gi, 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    end

    // Back-to-back frames with start held high at CLK_DIV=1.
    b_op = 2'($urandom); b_a = 3'($urandom); b_b = 3'($urandom);
    @(negedge clk);
    op[1] = b_op; a[1] = b_a; b[1] = b_b; start[1] = 1'b1;
    prev_cs = 1'b1; n_fall = 0; t_prev_fall = 0; high_run = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (cs[1] === 1'b0 && prev_cs === 1'b1) begin
        if (n_fall > 0) begin
          check("b2b_period", 32'((t - t_prev_fall) >= 26 && (t - t_prev_fall) <= 27), 32'd1);
          check("b2b_cs_gap", 32'(high_run >= 1), 32'd1);
        end
        n_fall++;
        t_prev_fall = t;
      end
      if (cs[1] === 1'b1) high_run++;
      else high_run = 0;
      if (done[1] === 1'b1) check("b2b_result", 32'(result[1]), 32'(ref_alu(b_op, b_a, b_b)));
      prev_cs = cs[1];
    end
    check("b2b_frames", 32'(n_fall >= 3), 32'd1);
    start[1] = 1'b0;
    waited = 0;
    while (busy[1] !== 1'b0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_idle", 32'(busy[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
